// File: rtl/dmac_ahb_slv_regs.sv
// AHB slave register file of the DMAC: host decode, per-channel configuration export,
// and completion interrupt collection.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no data phase in progress, ready for an address phase
// ST_WR      | write data phase, register updated at the closing edge
// ST_RD_WAIT | read wait state, register captured at the closing edge
// ST_RD_DONE | read data phase, s_hrdata valid
// ST_ERR1    | first ERROR cycle, s_hready low
// ST_ERR2    | second ERROR cycle, s_hready high
module dmac_ahb_slv_regs #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 12
) (
  input  logic                 hclk,
  input  logic                 hrst,
  input  logic                 s_hsel,
  input  logic [31:0]          s_haddr,
  input  logic [1:0]           s_htrans,
  input  logic                 s_hwrite,
  input  logic [3:0]           s_hprot,
  input  logic [31:0]          s_hwdata,
  output logic [31:0]          s_hrdata,
  output logic                 s_hready,
  output logic [1:0]           s_hresp,
  input  logic [NUM_CH-1:0]    ch_done,
  output logic [NUM_CH-1:0]    ch_en,
  output logic [NUM_CH*32-1:0] ch_src,
  output logic [NUM_CH*32-1:0] ch_dst,
  output logic [NUM_CH*16-1:0] ch_len,
  output logic                 irq
);

  localparam logic [31:0] ID_VAL = 32'h444D_4143;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_RD_WAIT, ST_RD_DONE, ST_ERR1, ST_ERR2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] off, a_off;
  logic              accept, acc_err;
  logic              in_lo, in_ch, in_mapped, in_id;

  logic [31:0]       scratch_q, ctrl_q, rd_val, rdata_q;
  logic [NUM_CH-1:0] int_stat_q, int_mask_q, cfg_en_q, w1c_mask;
  logic [31:0]       src_q [NUM_CH];
  logic [31:0]       dst_q [NUM_CH];
  logic [15:0]       len_q [NUM_CH];

  logic       wr_now, a_lo, a_ch;
  logic [3:0] a_idx;
  logic [1:0] a_fld;

  logic unused_bits;
  assign unused_bits = ^{s_hprot, s_haddr[31:ADDR_W], s_htrans[0]};

  // Address-phase decode on the live bus
  assign off       = s_haddr[ADDR_W-1:0];
  assign in_lo     = (off[ADDR_W-1:8] == '0);
  assign in_ch     = (off[ADDR_W-1:8] == (ADDR_W-8)'(1));
  assign in_id     = in_lo && (off[7:0] == 8'h10);
  assign in_mapped = (in_lo && (off[7:0] inside {8'h00, 8'h04, 8'h08, 8'h0C, 8'h10}))
                  || (in_ch && (int'(off[7:4]) < NUM_CH));
  assign accept    = s_hsel & s_htrans[1] & s_hready;
  assign acc_err   = (s_haddr[1:0] != 2'b00) | ~in_mapped | (s_hwrite & in_id);

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q <= ST_IDLE;
      a_off   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) a_off <= off;
    end
  end

  always_comb begin
    state_d  = ST_IDLE;
    s_hready = 1'b1;
    s_hresp  = 2'b00;
    case (state_q)
      ST_RD_WAIT: begin
        state_d  = ST_RD_DONE;
        s_hready = 1'b0;
      end
      ST_ERR1: begin
        state_d  = ST_ERR2;
        s_hready = 1'b0;
        s_hresp  = 2'b01;
      end
      default: begin
        if (state_q == ST_ERR2) s_hresp = 2'b01;
        // s_hready is high in every state handled here, so it is left out of the accept term
        if (s_hsel && s_htrans[1]) begin
          if (acc_err)       state_d = ST_ERR1;
          else if (s_hwrite) state_d = ST_WR;
          else               state_d = ST_RD_WAIT;
        end
      end
    endcase
  end

  // Data-phase decode on the latched address
  assign wr_now   = (state_q == ST_WR);
  assign a_lo     = (a_off[ADDR_W-1:8] == '0);
  assign a_ch     = (a_off[ADDR_W-1:8] == (ADDR_W-8)'(1));
  assign a_idx    = a_off[7:4];
  assign a_fld    = a_off[3:2];
  assign w1c_mask = (wr_now && a_lo && a_off[7:0] == 8'h08) ? s_hwdata[NUM_CH-1:0] : '0;

  always_comb begin
    rd_val = '0;
    if (a_lo) begin
      case (a_off[7:0])
        8'h00:   rd_val = scratch_q;
        8'h04:   rd_val = ctrl_q;
        8'h08:   rd_val[NUM_CH-1:0] = int_stat_q;
        8'h0C:   rd_val[NUM_CH-1:0] = int_mask_q;
        8'h10:   rd_val = ID_VAL;
        default: rd_val = '0;
      endcase
    end else if (a_ch) begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (a_idx == 4'(n)) begin
          case (a_fld)
            2'd0: rd_val = src_q[n];
            2'd1: rd_val = dst_q[n];
            2'd2: rd_val[15:0] = len_q[n];
            default: rd_val[0] = cfg_en_q[n];
          endcase
        end
      end
    end
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      scratch_q  <= '0;
      ctrl_q     <= '0;
      int_stat_q <= '0;
      int_mask_q <= '0;
      cfg_en_q   <= '0;
      rdata_q    <= '0;
      irq        <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        src_q[n] <= '0;
        dst_q[n] <= '0;
        len_q[n] <= '0;
      end
    end else begin
      if (wr_now && a_lo && a_off[7:0] == 8'h00) scratch_q  <= s_hwdata;
      if (wr_now && a_lo && a_off[7:0] == 8'h04) ctrl_q     <= s_hwdata;
      if (wr_now && a_lo && a_off[7:0] == 8'h0C) int_mask_q <= s_hwdata[NUM_CH-1:0];
      int_stat_q <= (int_stat_q & ~w1c_mask) | ch_done;
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_done[n]) cfg_en_q[n] <= 1'b0;
        // a host write in the same cycle overrides the completion clear
        if (wr_now && a_ch && a_idx == 4'(n)) begin
          case (a_fld)
            2'd0: src_q[n]    <= s_hwdata;
            2'd1: dst_q[n]    <= s_hwdata;
            2'd2: len_q[n]    <= s_hwdata[15:0];
            default: cfg_en_q[n] <= s_hwdata[0];
          endcase
        end
      end
      rdata_q <= (state_q == ST_RD_WAIT) ? rd_val : '0;
      irq     <= |(int_stat_q & int_mask_q);
    end
  end

  assign s_hrdata = rdata_q;

  always_comb begin
    ch_en  = '0;
    ch_src = '0;
    ch_dst = '0;
    ch_len = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_en[n]          = cfg_en_q[n] & ctrl_q[0];
      ch_src[32*n +: 32] = src_q[n];
      ch_dst[32*n +: 32] = dst_q[n];
      ch_len[16*n +: 16] = len_q[n];
    end
  end

endmodule

// File: tb/tb_dmac_ahb_slv_regs.sv
// Directed bench for dmac_ahb_slv_regs: register access, error responses,
// channel programming, interrupts, pipelining and asynchronous reset.
module tb_dmac_ahb_slv_regs;

  localparam int NUM_CH = 2;

  logic                 hclk, hrst;
  logic                 s_hsel, s_hwrite;
  logic [31:0]          s_haddr, s_hwdata, s_hrdata;
  logic [1:0]           s_htrans, s_hresp;
  logic [3:0]           s_hprot;
  logic                 s_hready, irq;
  logic [NUM_CH-1:0]    ch_done, ch_en;
  logic [NUM_CH*32-1:0] ch_src, ch_dst;
  logic [NUM_CH*16-1:0] ch_len;

  int n_tests = 0;
  int n_fail  = 0;

  dmac_ahb_slv_regs #(.NUM_CH(NUM_CH), .ADDR_W(12)) dut (
    .hclk(hclk), .hrst(hrst),
    .s_hsel(s_hsel), .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite),
    .s_hprot(s_hprot), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp),
    .ch_done(ch_done), .ch_en(ch_en), .ch_src(ch_src), .ch_dst(ch_dst),
    .ch_len(ch_len), .irq(irq)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // One transfer; starts just after a rising edge and returns just after the closing edge.
  task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [NUM_CH-1:0] done, output logic [31:0] rdata,
                          output int cycles, output int errs);
    bit fin;
    s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = addr; s_hwrite = wr;
    @(posedge hclk); #1;
    s_hsel = 1'b0; s_htrans = 2'b00; s_hwrite = 1'b0; s_hwdata = wdata; ch_done = done;
    cycles = 0; errs = 0; rdata = '0; fin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge hclk);
      cycles++;
      if (s_hresp == 2'b01) errs++;
      if (s_hready) begin
        rdata = s_hrdata;
        fin = 1'b1;
        break;
      end
      @(posedge hclk); #1;
      ch_done = '0;
    end
    if (!fin) cycles = 99;
    @(posedge hclk); #1;
    ch_done = '0;
  endtask

  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd; int c, e;
    ahb_xfer(addr, 1'b1, data, '0, rd, c, e);
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    int c, e;
    ahb_xfer(addr, 1'b0, '0, '0, data, c, e);
  endtask

  task automatic test_reset();
    hrst = 1'b1; s_hsel = 0; s_haddr = 0; s_htrans = 0; s_hwrite = 0; s_hprot = 0;
    s_hwdata = 0; ch_done = '0;
    #3;
    n_tests++; if (s_hready !== 1'b1) begin n_fail++; $display("FAIL reset_hready got %b exp 1", s_hready); end
    n_tests++; if (s_hresp !== 2'b00) begin n_fail++; $display("FAIL reset_hresp got %b exp 00", s_hresp); end
    n_tests++; if (s_hrdata !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata got %h exp 0", s_hrdata); end
    n_tests++; if ({ch_en, ch_src, ch_dst, ch_len, irq} !== '0) begin n_fail++; $display("FAIL reset_outputs got en=%b src=%h irq=%b exp 0", ch_en, ch_src, irq); end
    @(posedge hclk); #1;
    hrst = 1'b0;
  endtask

  task automatic test_rw();
    logic [31:0] rd; int c, e;
    ahb_xfer(32'h000, 1'b1, 32'h5a5a5a5a, '0, rd, c, e);
    n_tests++; if (c !== 1 || e !== 0) begin n_fail++; $display("FAIL write_timing got cycles=%0d errs=%0d exp 1/0", c, e); end
    ahb_xfer(32'h000, 1'b0, '0, '0, rd, c, e);
    n_tests++; if (rd !== 32'h5a5a5a5a) begin n_fail++; $display("FAIL scratch_rd got %h exp 5a5a5a5a", rd); end
    n_tests++; if (c !== 2 || e !== 0) begin n_fail++; $display("FAIL read_timing got cycles=%0d errs=%0d exp 2/0", c, e); end
    ahb_write(32'h004, 32'hffff0000);
    ahb_xfer(32'h004, 1'b0, '0, '0, rd, c, e);
    n_tests++; if (rd !== 32'hffff0000 || c !== 2) begin n_fail++; $display("FAIL ctrl_rd got %h cycles=%0d exp ffff0000/2", rd, c); end
  endtask

  task automatic test_id_err();
    logic [31:0] rd; int c, e;
    logic [31:0] bad [3] = '{32'h002, 32'h020, 32'h120};
    ahb_read(32'h010, rd);
    n_tests++; if (rd !== 32'h444D4143) begin n_fail++; $display("FAIL id_rd got %h exp 444d4143", rd); end
    ahb_xfer(32'h010, 1'b1, 32'h0, '0, rd, c, e);
    n_tests++; if (c !== 2 || e !== 2) begin n_fail++; $display("FAIL id_wr_err got cycles=%0d errs=%0d exp 2/2", c, e); end
    ahb_read(32'h010, rd);
    n_tests++; if (rd !== 32'h444D4143) begin n_fail++; $display("FAIL id_after_err got %h exp 444d4143", rd); end
    for (int i = 0; i < 3; i++) begin
      ahb_xfer(bad[i], 1'b1, 32'hdeadbeef, '0, rd, c, e);
      n_tests++; if (c !== 2 || e !== 2) begin n_fail++; $display("FAIL bad_wr_%h got cycles=%0d errs=%0d exp 2/2", bad[i], c, e); end
      ahb_xfer(bad[i], 1'b0, '0, '0, rd, c, e);
      n_tests++; if (c !== 2 || e !== 2 || rd !== 32'h0) begin n_fail++; $display("FAIL bad_rd_%h got cycles=%0d errs=%0d data=%h exp 2/2/0", bad[i], c, e, rd); end
    end
    ahb_read(32'h000, rd);
    n_tests++; if (rd !== 32'h5a5a5a5a) begin n_fail++; $display("FAIL scratch_kept got %h exp 5a5a5a5a", rd); end
    ahb_read(32'h004, rd);
    n_tests++; if (rd !== 32'hffff0000) begin n_fail++; $display("FAIL ctrl_kept got %h exp ffff0000", rd); end
    n_tests++; if (ch_src !== '0 || ch_en !== '0) begin n_fail++; $display("FAIL ch_untouched got src=%h en=%b exp 0", ch_src, ch_en); end
  endtask

  task automatic test_channel();
    logic [31:0] rd;
    ahb_write(32'h110, 32'h1000);
    ahb_write(32'h114, 32'h2000);
    ahb_write(32'h118, 32'h0040);
    ahb_write(32'h11C, 32'h1);
    ahb_write(32'h004, 32'h1);
    n_tests++; if (ch_en !== 2'b10) begin n_fail++; $display("FAIL ch_en_on got %b exp 10", ch_en); end
    n_tests++; if (ch_src[63:32] !== 32'h1000 || ch_src[31:0] !== 32'h0) begin n_fail++; $display("FAIL ch_src got %h exp 00001000_00000000", ch_src); end
    n_tests++; if (ch_dst[63:32] !== 32'h2000) begin n_fail++; $display("FAIL ch_dst got %h exp 2000", ch_dst[63:32]); end
    n_tests++; if (ch_len !== 32'h0040_0000) begin n_fail++; $display("FAIL ch_len got %h exp 00400000", ch_len); end
    ch_done = 2'b10;
    @(posedge hclk); #1;
    ch_done = 2'b00;
    n_tests++; if (ch_en !== 2'b00) begin n_fail++; $display("FAIL ch_en_done got %b exp 00", ch_en); end
    ahb_read(32'h008, rd);
    n_tests++; if (rd !== 32'h2) begin n_fail++; $display("FAIL int_stat_set got %h exp 2", rd); end
    ahb_write(32'h00C, 32'h2);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_lag got %b exp 0", irq); end
    @(posedge hclk); #1;
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", irq); end
    ahb_write(32'h008, 32'h2);
    @(posedge hclk); #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr got %b exp 0", irq); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd; int c, e;
    ahb_xfer(32'h008, 1'b1, 32'h1, 2'b01, rd, c, e);
    ahb_read(32'h008, rd);
    n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL set_beats_w1c got %h exp 1", rd); end
    ahb_xfer(32'h10C, 1'b1, 32'h1, 2'b01, rd, c, e);
    ahb_read(32'h10C, rd);
    n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL cfg_write_wins got %h exp 1", rd); end
    n_tests++; if (ch_en !== 2'b01) begin n_fail++; $display("FAIL ch0_en got %b exp 01", ch_en); end
  endtask

  task automatic test_back_to_back();
    s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = 32'h000; s_hwrite = 1'b1;
    @(posedge hclk); #1;
    s_hwrite = 1'b0; s_hwdata = 32'h12345678;
    n_tests++; if (s_hready !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready got %b exp 1", s_hready); end
    @(posedge hclk); #1;
    s_hsel = 1'b0; s_htrans = 2'b00;
    @(negedge hclk);
    n_tests++; if (s_hready !== 1'b0) begin n_fail++; $display("FAIL b2b_wait got %b exp 0", s_hready); end
    @(negedge hclk);
    n_tests++; if (s_hready !== 1'b1 || s_hrdata !== 32'h12345678) begin n_fail++; $display("FAIL b2b_rd got ready=%b data=%h exp 1/12345678", s_hready, s_hrdata); end
    @(posedge hclk); #1;
    n_tests++; if (s_hrdata !== 32'h0) begin n_fail++; $display("FAIL rdata_idle got %h exp 0", s_hrdata); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    s_hsel = 1'b1; s_htrans = 2'b10; s_haddr = 32'h000; s_hwrite = 1'b0;
    @(posedge hclk); #1;
    s_hsel = 1'b0; s_htrans = 2'b00;
    @(negedge hclk);
    n_tests++; if (s_hready !== 1'b0) begin n_fail++; $display("FAIL mid_wait got %b exp 0", s_hready); end
    #1 hrst = 1'b1;
    #1;
    n_tests++; if (s_hready !== 1'b1 || s_hrdata !== 32'h0 || s_hresp !== 2'b00) begin n_fail++; $display("FAIL mid_async got ready=%b data=%h resp=%b exp 1/0/00", s_hready, s_hrdata, s_hresp); end
    n_tests++; if ({ch_en, ch_src, ch_dst, ch_len, irq} !== '0) begin n_fail++; $display("FAIL mid_outputs got en=%b src=%h exp 0", ch_en, ch_src); end
    @(posedge hclk); #1;
    hrst = 1'b0;
    ahb_read(32'h000, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL post_scratch got %h exp 0", rd); end
    ahb_read(32'h008, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL post_int_stat got %h exp 0", rd); end
    ahb_read(32'h114, rd);
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL post_dst1 got %h exp 0", rd); end
  endtask

  initial begin
    test_reset();
    test_rw();
    test_id_err();
    test_channel();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
